// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: byte RAM with one-cycle read latency,
// plus an I/O window holding UART TX/RX FIFOs, a cycle counter and a stop sequencer.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_WIDTH  = 4,
    parameter int RX_FIFO_WIDTH  = 4,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_halt
);

    localparam int TX_DEPTH = 1 << TX_FIFO_WIDTH;
    localparam int RX_DEPTH = 1 << RX_FIFO_WIDTH;

    typedef logic [TX_FIFO_WIDTH-1:0] tx_ptr_t;
    typedef logic [TX_FIFO_WIDTH:0]   tx_cnt_t;
    typedef logic [RX_FIFO_WIDTH-1:0] rx_ptr_t;
    typedef logic [RX_FIFO_WIDTH:0]   rx_cnt_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOPPING,
        ST_HALTED
    } state_t;

    logic [7:0] ram    [2**RAM_ADDR_WIDTH];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    state_t     state_q, state_d;
    logic       zero_sent_q, zero_sent_d;
    tx_ptr_t    tx_wr_ptr_q, tx_wr_ptr_d;
    tx_ptr_t    tx_rd_ptr_q, tx_rd_ptr_d;
    tx_cnt_t    tx_count_q, tx_count_d;
    rx_ptr_t    rx_wr_ptr_q, rx_wr_ptr_d;
    rx_ptr_t    rx_rd_ptr_q, rx_rd_ptr_d;
    rx_cnt_t    rx_count_q, rx_count_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic       io_buffer_full_q, io_buffer_full_d;
    logic       program_halt_q, program_halt_d;

    logic [1:0]                region;
    logic [2:0]                io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      is_ram;
    logic                      is_io;
    logic                      cpu_wr_en;
    logic                      cpu_rd_en;
    logic                      ram_we;
    logic                      tx_not_empty;
    logic                      tx_pop;
    logic                      tx_room;
    logic                      data_push;
    logic                      stop_wr;
    logic                      zero_push;
    logic                      tx_push;
    logic [7:0]                tx_push_data;
    logic                      rx_pop;
    logic                      rx_push;
    logic                      snap_rd;
    logic                      unused_addr_bits;

    assign region           = cpu_addr[17:16];
    assign io_off           = cpu_addr[2:0];
    assign ram_idx          = cpu_addr[RAM_ADDR_WIDTH-1:0];
    assign is_ram           = ~region[1];
    assign is_io            = &region;
    assign unused_addr_bits = ^cpu_addr[31:18];

    // Halted blocks every CPU write; reads are still serviced.
    assign cpu_wr_en = rdy_in & cpu_wr & (state_q != ST_HALTED);
    assign cpu_rd_en = rdy_in & ~cpu_wr;
    assign ram_we    = cpu_wr_en & is_ram;

    assign tx_not_empty = (tx_count_q != '0);
    assign tx_pop       = tx_not_empty & tx_ready;
    assign tx_room      = (tx_count_q != tx_cnt_t'(TX_DEPTH)) | tx_pop;

    // Once stopping, only the terminating 0x00 may enter TX so it stays last.
    assign data_push = cpu_wr_en & is_io & (io_off == 3'd0) & (state_q == ST_RUN)
                     & (cpu_wdata != 8'h00) & tx_room;
    assign stop_wr   = cpu_wr_en & is_io & (io_off == 3'd4) & (state_q == ST_RUN);
    assign zero_push = tx_room & (stop_wr | (rdy_in & (state_q == ST_STOPPING) & ~zero_sent_q));
    assign tx_push      = data_push | zero_push;
    assign tx_push_data = zero_push ? 8'h00 : cpu_wdata;

    assign rx_pop  = cpu_rd_en & is_io & (io_off == 3'd0) & (rx_count_q != '0);
    assign rx_push = rx_valid & ((rx_count_q != rx_cnt_t'(RX_DEPTH)) | rx_pop);
    assign snap_rd = cpu_rd_en & is_io & (io_off == 3'd4);

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        if (cpu_rd_en) begin
            case (region)
                2'b00, 2'b01: cpu_rdata_d = ram[ram_idx];
                2'b10:        cpu_rdata_d = 8'h00;
                default: begin
                    case (io_off)
                        3'd0:    cpu_rdata_d = (rx_count_q != '0) ? rx_mem[rx_rd_ptr_q] : 8'h00;
                        3'd4:    cpu_rdata_d = counter_q[7:0];
                        3'd5:    cpu_rdata_d = snapshot_q[15:8];
                        3'd6:    cpu_rdata_d = snapshot_q[23:16];
                        3'd7:    cpu_rdata_d = snapshot_q[31:24];
                        default: cpu_rdata_d = 8'h00;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + tx_ptr_t'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + tx_ptr_t'(1) : tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + tx_cnt_t'(1);
        end else if (!tx_push && tx_pop) begin
            tx_count_d = tx_count_q - tx_cnt_t'(1);
        end

        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + rx_ptr_t'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + rx_ptr_t'(1) : rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + rx_cnt_t'(1);
        end else if (!rx_push && rx_pop) begin
            rx_count_d = rx_count_q - rx_cnt_t'(1);
        end

        counter_d  = (rdy_in && state_q != ST_HALTED) ? counter_q + 32'd1 : counter_q;
        snapshot_d = snap_rd ? counter_q : snapshot_q;

        // Derived from the next count so the flag lines up with the push that fills TX.
        io_buffer_full_d = (TX_DEPTH - int'(tx_count_d)) <= FULL_MARGIN;
    end

    always_comb begin
        state_d     = state_q;
        zero_sent_d = zero_sent_q;
        case (state_q)
            ST_RUN: begin
                if (stop_wr) begin
                    state_d     = ST_STOPPING;
                    zero_sent_d = tx_room;
                end
            end
            ST_STOPPING: begin
                if (rdy_in) begin
                    if (zero_push) begin
                        zero_sent_d = 1'b1;
                    end
                    if (zero_sent_q && tx_count_q == '0) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: state_d = ST_HALTED;
        endcase
        program_halt_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= ST_RUN;
            zero_sent_q      <= 1'b0;
            tx_wr_ptr_q      <= '0;
            tx_rd_ptr_q      <= '0;
            tx_count_q       <= '0;
            rx_wr_ptr_q      <= '0;
            rx_rd_ptr_q      <= '0;
            rx_count_q       <= '0;
            counter_q        <= '0;
            snapshot_q       <= '0;
            cpu_rdata_q      <= '0;
            io_buffer_full_q <= 1'b0;
            program_halt_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            zero_sent_q      <= zero_sent_d;
            tx_wr_ptr_q      <= tx_wr_ptr_d;
            tx_rd_ptr_q      <= tx_rd_ptr_d;
            tx_count_q       <= tx_count_d;
            rx_wr_ptr_q      <= rx_wr_ptr_d;
            rx_rd_ptr_q      <= rx_rd_ptr_d;
            rx_count_q       <= rx_count_d;
            counter_q        <= counter_d;
            snapshot_q       <= snapshot_d;
            cpu_rdata_q      <= cpu_rdata_d;
            io_buffer_full_q <= io_buffer_full_d;
            program_halt_q   <= program_halt_d;
        end
    end

    // Storage arrays carry no reset; pointers and counts define what is valid.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= cpu_wdata;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= tx_push_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rx_data;
        end
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign io_buffer_full = io_buffer_full_q;
    assign tx_data        = tx_mem[tx_rd_ptr_q];
    assign tx_valid       = tx_not_empty;
    assign program_halt   = program_halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a randomized
// phase, all checked cycle by cycle against a queue-based behavioural model.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_halt;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_wr         (cpu_wr),
        .cpu_rdata      (cpu_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_halt   (program_halt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: RAM as a sparse map, FIFOs as queues, stop sequencer as 0/1/2.
    logic [7:0]  ramM [int];
    logic [7:0]  txQ [$];
    logic [7:0]  rxQ [$];
    logic [31:0] cntM;
    logic [31:0] snapM;
    int          stM;
    bit          zeroDoneM;
    logic [7:0]  rdataM;
    bit          fullM;
    bit          haltM;

    logic [7:0]  dutEmit [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        txQ.delete();
        rxQ.delete();
        cntM      = 32'd0;
        snapM     = 32'd0;
        stM       = 0;
        zeroDoneM = 1'b0;
        rdataM    = 8'h00;
        fullM     = 1'b0;
        haltM     = 1'b0;
    endtask

    task automatic modelStep();
        logic [1:0] rgn;
        logic [2:0] off;
        int         idx;
        bit         halted;
        bit         txPop;
        bit         txRoom;
        bit         rxPop;
        bit         pushTx;
        bit         doneStopping;
        logic [7:0] pushByte;
        rgn          = cpu_addr[17:16];
        off          = cpu_addr[2:0];
        idx          = int'(cpu_addr[16:0]);
        halted       = (stM == 2);
        txPop        = (txQ.size() != 0) && tx_ready;
        txRoom       = (txQ.size() < 16) || txPop;
        doneStopping = (stM == 1) && zeroDoneM && (txQ.size() == 0);
        rxPop        = 1'b0;
        pushTx       = 1'b0;
        pushByte     = 8'h00;
        if (rdy_in) begin
            if (!cpu_wr) begin
                if (rgn <= 2'd1) begin
                    rdataM = ramM.exists(idx) ? ramM[idx] : 8'h00;
                end else if (rgn == 2'd2) begin
                    rdataM = 8'h00;
                end else begin
                    case (off)
                        3'd0: begin
                            if (rxQ.size() != 0) begin
                                rdataM = rxQ[0];
                                rxPop  = 1'b1;
                            end else begin
                                rdataM = 8'h00;
                            end
                        end
                        3'd4: begin
                            rdataM = cntM[7:0];
                            snapM  = cntM;
                        end
                        3'd5:    rdataM = snapM[15:8];
                        3'd6:    rdataM = snapM[23:16];
                        3'd7:    rdataM = snapM[31:24];
                        default: rdataM = 8'h00;
                    endcase
                end
            end else if (!halted) begin
                if (rgn <= 2'd1) begin
                    ramM[idx] = cpu_wdata;
                end else if (rgn == 2'd3 && stM == 0 && off == 3'd0) begin
                    if (cpu_wdata != 8'h00 && txRoom) begin
                        pushTx   = 1'b1;
                        pushByte = cpu_wdata;
                    end
                end else if (rgn == 2'd3 && stM == 0 && off == 3'd4) begin
                    stM       = 1;
                    zeroDoneM = 1'b0;
                end
            end
            if (stM == 1 && !zeroDoneM && txRoom) begin
                pushTx    = 1'b1;
                pushByte  = 8'h00;
                zeroDoneM = 1'b1;
            end
            if (doneStopping) begin
                stM = 2;
            end
            if (!halted) begin
                cntM = cntM + 32'd1;
            end
        end
        if (txPop) begin
            void'(txQ.pop_front());
        end
        if (pushTx) begin
            txQ.push_back(pushByte);
        end
        if (rxPop) begin
            void'(rxQ.pop_front());
        end
        if (rx_valid && rxQ.size() < 16) begin
            rxQ.push_back(rx_data);
        end
        fullM = (16 - txQ.size()) <= 2;
        haltM = (stM == 2);
    endtask

    task automatic checkAll();
        checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(rdataM));
        checkOutput("tx_valid", 32'(tx_valid), 32'(txQ.size() != 0));
        if (txQ.size() != 0) begin
            checkOutput("tx_data", 32'(tx_data), 32'(txQ[0]));
        end
        checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(fullM));
        checkOutput("program_halt", 32'(program_halt), 32'(haltM));
    endtask

    task automatic applyStimulus(input bit rdy, input bit wr, input logic [31:0] a,
                                 input logic [7:0] d, input bit rxv, input logic [7:0] rxd);
        rdy_in    = rdy;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        rx_valid  = rxv;
        rx_data   = rxd;
        if (tx_valid && tx_ready) begin
            dutEmit.push_back(tx_data);
        end
        @(posedge clk_in);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic cpuWrite(input logic [31:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic cpuRead(input logic [31:0] a);
        applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0002_0000, 8'h00, 1'b0, 8'h00);
        end
    endtask

    function automatic logic [31:0] randRamAddr();
        logic [31:0] top;
        logic [31:0] a;
        top = $urandom;
        a   = (($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'h0) + 32'($urandom_range(0, 15));
        a[31:18] = top[13:0];
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b4;
        logic [7:0]  b5;
        logic [7:0]  b6;
        logic [7:0]  b7;
        logic [31:0] a;
        int          op;

        rst_in    = 1'b1;
        rdy_in    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        modelReset();
        #3;
        checkOutput("reset_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("reset_buf_full", 32'(io_buffer_full), 32'h0);
        checkOutput("reset_halt", 32'(program_halt), 32'h0);
        #9;
        rst_in = 1'b0;

        $display("[TB] RAM write/read and hole");
        cpuWrite(32'h0001_1, 8'h3C);
        cpuWrite(32'h0000_0010, 8'hA5);
        cpuRead(32'h0000_0010);
        checkOutput("ram_raw", 32'(cpu_rdata), 32'hA5);
        cpuRead(32'h0000_0011);
        checkOutput("ram_preload", 32'(cpu_rdata), 32'h3C);
        cpuWrite(32'h0002_0010, 8'h77);
        cpuRead(32'h0002_0010);
        checkOutput("hole_read", 32'(cpu_rdata), 32'h0);

        $display("[TB] TX string with zero terminator");
        tx_ready = 1'b1;
        dutEmit.delete();
        cpuWrite(32'h0003_0000, 8'h48);
        cpuWrite(32'h0003_0000, 8'h69);
        cpuWrite(32'h0003_0000, 8'h00);
        idle(6);
        checkOutput("hi_count", 32'(dutEmit.size()), 32'd2);
        if (dutEmit.size() == 2) begin
            checkOutput("hi_byte0", 32'(dutEmit[0]), 32'h48);
            checkOutput("hi_byte1", 32'(dutEmit[1]), 32'h69);
        end

        $display("[TB] TX fill, near-full flag and overflow drop");
        tx_ready = 1'b0;
        dutEmit.delete();
        for (int i = 0; i < 17; i++) begin
            cpuWrite(32'h0003_0000, 8'(8'h41 + i));
            if (i == 12) checkOutput("buf_full_13", 32'(io_buffer_full), 32'h0);
            if (i == 13) checkOutput("buf_full_14", 32'(io_buffer_full), 32'h1);
        end
        tx_ready = 1'b1;
        idle(20);
        checkOutput("fill_count", 32'(dutEmit.size()), 32'd16);
        for (int i = 0; i < dutEmit.size() && i < 16; i++) begin
            checkOutput("fill_order", 32'(dutEmit[i]), 32'(8'h41 + i));
        end

        $display("[TB] cycle counter and snapshot");
        idle(100);
        cpuRead(32'h0003_0004);
        b0 = cpu_rdata;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 8'h00);
        end
        cpuRead(32'h0003_0004);
        b4 = cpu_rdata;
        checkOutput("cnt_frozen_rdy", 32'(b4), 32'(8'(b0 + 8'd1)));
        cpuRead(32'h0003_0005);
        b5 = cpu_rdata;
        cpuRead(32'h0003_0006);
        b6 = cpu_rdata;
        cpuRead(32'h0003_0007);
        b7 = cpu_rdata;
        checkOutput("snapshot", {b7, b6, b5, b4}, snapM);

        $display("[TB] RX FIFO");
        applyStimulus(1'b1, 1'b0, 32'h0002_0000, 8'h00, 1'b1, 8'h31);
        applyStimulus(1'b1, 1'b0, 32'h0002_0000, 8'h00, 1'b1, 8'h32);
        cpuRead(32'h0003_0000);
        checkOutput("rx_first", 32'(cpu_rdata), 32'h31);
        cpuRead(32'h0003_0000);
        checkOutput("rx_second", 32'(cpu_rdata), 32'h32);
        cpuRead(32'h0003_0000);
        checkOutput("rx_empty", 32'(cpu_rdata), 32'h00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16; i++) begin
            cpuWrite(32'(i), 8'($urandom));
            cpuWrite(32'h0001_0000 + 32'(i), 8'($urandom));
        end
        for (int n = 0; n < 600; n++) begin
            op       = $urandom_range(0, 9);
            tx_ready = 1'($urandom_range(0, 1));
            a        = 32'h0003_0000;
            case (op)
                0, 1: applyStimulus($urandom_range(0, 9) != 0, 1'b1, randRamAddr(), 8'($urandom),
                                    $urandom_range(0, 3) == 0, 8'($urandom));
                2, 3: applyStimulus($urandom_range(0, 9) != 0, 1'b0, randRamAddr(), 8'h00,
                                    $urandom_range(0, 3) == 0, 8'($urandom));
                4: applyStimulus($urandom_range(0, 9) != 0, 1'b1, a,
                                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                                 $urandom_range(0, 3) == 0, 8'($urandom));
                5, 6: applyStimulus($urandom_range(0, 9) != 0, 1'b0, a + 32'($urandom_range(0, 7)),
                                    8'h00, $urandom_range(0, 3) == 0, 8'($urandom));
                7: applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                                 32'h0002_0000 + 32'($urandom_range(0, 255)), 8'($urandom),
                                 $urandom_range(0, 3) == 0, 8'($urandom));
                default: applyStimulus($urandom_range(0, 9) != 0, 1'b1,
                                       a + 32'($urandom_range(1, 3) + (($urandom_range(0, 1) == 1) ? 4 : 0)),
                                       8'($urandom), $urandom_range(0, 1) == 0, 8'($urandom));
            endcase
        end

        $display("[TB] stop sequencer");
        tx_ready = 1'b1;
        idle(20);
        tx_ready = 1'b0;
        dutEmit.delete();
        cpuWrite(32'h0003_0000, 8'h61);
        cpuWrite(32'h0003_0000, 8'h62);
        cpuWrite(32'h0003_0000, 8'h63);
        cpuWrite(32'h0003_0004, 8'h00);
        cpuWrite(32'h0003_0004, 8'h00);
        checkOutput("stop_not_halted", 32'(program_halt), 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 30 && tx_valid; i++) begin
            idle(1);
        end
        checkOutput("stop_drained", 32'(tx_valid), 32'h0);
        checkOutput("stop_emit_count", 32'(dutEmit.size()), 32'd4);
        if (dutEmit.size() == 4) begin
            checkOutput("stop_emit0", 32'(dutEmit[0]), 32'h61);
            checkOutput("stop_emit1", 32'(dutEmit[1]), 32'h62);
            checkOutput("stop_emit2", 32'(dutEmit[2]), 32'h63);
            checkOutput("stop_emit3", 32'(dutEmit[3]), 32'h00);
        end
        idle(1);
        checkOutput("halt_asserted", 32'(program_halt), 32'h1);
        cpuWrite(32'h0000_0010, 8'h5A);
        cpuWrite(32'h0003_0000, 8'h55);
        cpuRead(32'h0000_0010);
        checkOutput("halted_ram_write", 32'(cpu_rdata), 32'hA5);
        cpuRead(32'h0003_0004);
        b0 = cpu_rdata;
        idle(3);
        cpuRead(32'h0003_0004);
        b1 = cpu_rdata;
        checkOutput("halted_cnt_frozen", 32'(b1), 32'(b0));
        cpuRead(32'h0000_0010);

        $display("[TB] asynchronous reset while halted");
        #3;
        rst_in = 1'b1;
        #1;
        checkOutput("arst_halt", 32'(program_halt), 32'h0);
        checkOutput("arst_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("arst_tx_valid", 32'(tx_valid), 32'h0);
        modelReset();
        #2;
        rst_in = 1'b0;
        cpuRead(32'h0003_0004);
        checkOutput("arst_counter", 32'(cpu_rdata), 32'h0);
        cpuRead(32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
